// File: rtl/arm_muldiv_unit.sv
// Iterative multiply/divide coprocessor: shift-add multiply and restoring divide,
// one bit per cycle, with a FIX cycle for sign correction and MLA accumulate.
module arm_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MLA   = 3'b001;
  localparam logic [2:0] OP_UMULL = 3'b010;
  localparam logic [2:0] OP_SMULL = 3'b011;
  localparam logic [2:0] OP_UDIV  = 3'b100;
  localparam logic [2:0] OP_SDIV  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] mb_q;
  logic [WIDTH-1:0] acc_q;
  logic             neg_q;
  logic             rneg_q;
  logic             dz_q;
  logic             il_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             n_q;
  logic             z_q;
  logic             dbz_q;
  logic             ill_q;

  logic             is_div;
  logic             is_ill;
  logic             is_sgn;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    is_div = (op == OP_UDIV) || (op == OP_SDIV);
    is_ill = (op[2:1] == 2'b11);
    is_sgn = (op == OP_SMULL) || (op == OP_SDIV);
    b_zero = (b == '0);
    a_mag  = (is_sgn && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_sgn && b[WIDTH-1]) ? -b : b;
  end

  // Multiply: lo holds the shrinking multiplier, hi the growing partial sum
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  always_comb begin
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_sub = div_sh - {1'b0, mb_q};
    div_ge  = (div_sh >= {1'b0, mb_q});
    div_hi  = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo  = {lo_q[WIDTH-2:0], div_ge};
  end

  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH-1:0]   fix_hi;
  logic [2*WIDTH-1:0] fix_neg;
  logic               fix_long;
  logic               fix_n;
  logic               fix_z;

  always_comb begin
    fix_lo  = lo_q;
    fix_hi  = hi_q;
    fix_neg = -{hi_q, lo_q};
    if (!(dz_q || il_q)) begin
      case (op_q)
        OP_MUL: fix_hi = '0;
        OP_MLA: begin
          fix_lo = lo_q + acc_q;
          fix_hi = '0;
        end
        OP_SMULL: begin
          if (neg_q) {fix_hi, fix_lo} = fix_neg;
        end
        OP_SDIV: begin
          if (neg_q) fix_lo = -lo_q;
          if (rneg_q) fix_hi = -hi_q;
        end
        default: ;
      endcase
    end
    fix_long = !il_q && ((op_q == OP_UMULL) || (op_q == OP_SMULL));
    fix_n    = fix_long ? fix_hi[WIDTH-1] : fix_lo[WIDTH-1];
    fix_z    = fix_long ? ({fix_hi, fix_lo} == '0) : (fix_lo == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      il_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            acc_q  <= acc;
            neg_q  <= is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q <= (op == OP_SDIV) && a[WIDTH-1];
            dz_q   <= is_div && b_zero;
            il_q   <= is_ill;
            dbz_q  <= 1'b0;
            ill_q  <= 1'b0;
            busy_q <= 1'b1;
            cnt_q  <= CW'(WIDTH - 1);
            mb_q   <= b_mag;
            if (is_ill) begin
              hi_q    <= '0;
              lo_q    <= '0;
              state_q <= S_FIX;
            end else if (is_div && b_zero) begin
              hi_q    <= a;
              lo_q    <= '0;
              state_q <= S_FIX;
            end else begin
              hi_q    <= '0;
              lo_q    <= a_mag;
              state_q <= S_CALC;
            end
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          hi_q <= op_q[2] ? div_hi : mul_hi;
          lo_q <= op_q[2] ? div_lo : mul_lo;
          if (cnt_q == '0) state_q <= S_FIX;
          else cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: begin
          state_q  <= S_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          res_lo_q <= fix_lo;
          res_hi_q <= fix_hi;
          n_q      <= fix_n;
          z_q      <= fix_z;
          dbz_q    <= dz_q;
          ill_q    <= il_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign flag_n      = n_q;
  assign flag_z      = z_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_arm_muldiv_unit.sv
// Directed bench for arm_muldiv_unit: vector table plus hand-written
// sequences for reset abort, ignored start and held start.
module tb_arm_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] acc;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         flag_n;
  logic         flag_z;
  logic         div_by_zero;
  logic         illegal_op;

  arm_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .acc(acc),
    .busy(busy),
    .done(done),
    .result_lo(result_lo),
    .result_hi(result_hi),
    .flag_n(flag_n),
    .flag_z(flag_z),
    .div_by_zero(div_by_zero),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] acc;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         n;
    logic         z;
    logic         dz;
    logic         il;
    int           lat;
  } vec_t;

  vec_t v[15];

  task automatic run(input vec_t t, input int idx);
    int k;
    bit busy_ok;
    op    = t.op;
    a     = t.a;
    b     = t.b;
    acc   = t.acc;
    start = 1'b1;
    tick();
    start   = 1'b0;
    k       = 1;
    busy_ok = 1'b1;
    chk($sformatf("v%0d err_clear", idx), {62'd0, div_by_zero, illegal_op}, 64'd0);
    while (!done && k < 100) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      k++;
    end
    chk($sformatf("v%0d latency", idx), 64'(k), 64'(t.lat));
    chk($sformatf("v%0d busy_during", idx), {63'd0, busy_ok}, 64'd1);
    chk($sformatf("v%0d busy_at_done", idx), {63'd0, busy}, 64'd0);
    chk($sformatf("v%0d lo", idx), {32'd0, result_lo}, {32'd0, t.lo});
    chk($sformatf("v%0d hi", idx), {32'd0, result_hi}, {32'd0, t.hi});
    chk($sformatf("v%0d n_z_dz_il", idx),
        {60'd0, flag_n, flag_z, div_by_zero, illegal_op},
        {60'd0, t.n, t.z, t.dz, t.il});
  endtask

  initial begin
    int k;
    int first;
    bit seen;

    v[0]  = '{3'b000, 32'd7, 32'd6, 32'd0, 32'd42, 32'd0, 0, 0, 0, 0, 34};
    v[1]  = '{3'b011, 32'hFFFFFFFE, 32'd3, 32'd0, 32'hFFFFFFFA, 32'hFFFFFFFF, 1, 0, 0, 0, 34};
    v[2]  = '{3'b010, 32'hFFFFFFFE, 32'd3, 32'd0, 32'hFFFFFFFA, 32'h00000002, 0, 0, 0, 0, 34};
    v[3]  = '{3'b101, 32'hFFFFFFF9, 32'd2, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1, 0, 0, 0, 34};
    v[4]  = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd0, 1, 0, 0, 0, 34};
    v[5]  = '{3'b100, 32'd100, 32'd0, 32'd0, 32'd0, 32'd100, 0, 1, 1, 0, 2};
    v[6]  = '{3'b100, 32'd100, 32'd7, 32'd0, 32'd14, 32'd2, 0, 0, 0, 0, 34};
    v[7]  = '{3'b001, 32'hFFFFFFFF, 32'd2, 32'd10, 32'd8, 32'd0, 0, 0, 0, 0, 34};
    v[8]  = '{3'b000, 32'h00010000, 32'h00010000, 32'd0, 32'd0, 32'd0, 0, 1, 0, 0, 34};
    v[9]  = '{3'b110, 32'd5, 32'd3, 32'd1, 32'd0, 32'd0, 0, 1, 0, 1, 2};
    v[10] = '{3'b101, 32'd7, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFD, 32'd1, 1, 0, 0, 0, 34};
    v[11] = '{3'b101, 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFB, 0, 1, 1, 0, 2};
    v[12] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h00000001, 32'hFFFFFFFE, 1, 0, 0, 0, 34};
    v[13] = '{3'b011, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h40000000, 0, 0, 0, 0, 34};
    v[14] = '{3'b001, 32'd0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1, 0, 0, 0, 34};

    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    acc   = '0;
    tick();
    tick();
    chk("reset busy_done", {62'd0, busy, done}, 64'd0);
    chk("reset results", {result_hi, result_lo}, 64'd0);
    chk("reset flags", {60'd0, flag_n, flag_z, div_by_zero, illegal_op}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) run(v[i], i);
    tick();
    tick();

    // Reset during cycle 10 of a MUL
    op    = 3'b000;
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("abort busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    chk("abort busy_done", {62'd0, busy, done}, 64'd0);
    chk("abort results", {result_hi, result_lo}, 64'd0);
    chk("abort flags", {60'd0, flag_n, flag_z, div_by_zero, illegal_op}, 64'd0);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("abort no_done", {63'd0, seen}, 64'd0);

    // Start pulsed while busy is ignored
    op    = 3'b000;
    a     = 32'd3;
    b     = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    k     = 1;
    repeat (3) begin
      tick();
      k++;
    end
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    tick();
    k++;
    start = 1'b0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("ignore latency", 64'(k), 64'd34);
    chk("ignore lo", {32'd0, result_lo}, 64'd12);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("ignore no_second", {63'd0, seen}, 64'd0);

    // Start held through DONE: operands captured at each acceptance
    op    = 3'b000;
    a     = 32'd2;
    b     = 32'd3;
    start = 1'b1;
    tick();
    k = 1;
    repeat (2) begin
      tick();
      k++;
    end
    a = 32'd5;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("held first_latency", 64'(k), 64'd34);
    chk("held first_lo", {32'd0, result_lo}, 64'd6);
    first = k;
    tick();
    k++;
    chk("held busy_next", {62'd0, busy, done}, 64'd2);
    while (!done && k < 200) begin
      tick();
      k++;
    end
    start = 1'b0;
    chk("held second_gap", 64'(k - first), 64'd34);
    chk("held second_lo", {32'd0, result_lo}, 64'd15);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
